median3x3_filter: RTL and testbench

MEDIAN3X3_FILTER -- requirements
Module: median3x3_filter

---
 rtl/median3x3_filter.sv | 178 +++++++++++++++++
 tb/tb_median3x3_filter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/median3x3_filter.sv
`default_nettype none
// ============================================================================
// Module      : median3x3_filter
// Description : Three-stage pipelined 3x3 median filter with optional
//               adaptive (impulse-only) replacement and a per-frame count of
//               replaced impulse pixels.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               in_valid, q00..q22  - window qualifier and 3x3 window
//                                     (qRC: row R oldest=0, column C oldest=0)
//               out_valid/out_pixel - filtered centre pixel and qualifier
//               out_sof / out_eol   - first pixel of frame / last of line
//               noise_count         - replaced impulses in last full frame
// Revision    : 1.0 - initial release
// ============================================================================
module median3x3_filter #(
    parameter int W        = 160,
    parameter int H        = 120,
    parameter int ADAPTIVE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  q00,
    input  logic [7:0]  q01,
    input  logic [7:0]  q02,
    input  logic [7:0]  q10,
    input  logic [7:0]  q11,
    input  logic [7:0]  q12,
    input  logic [7:0]  q20,
    input  logic [7:0]  q21,
    input  logic [7:0]  q22,
    output logic        out_valid,
    output logic [7:0]  out_pixel,
    output logic        out_sof,
    output logic        out_eol,
    output logic [14:0] noise_count
);

    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam int YW = (H > 1) ? $clog2(H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(H - 1);
    localparam logic [14:0]   NC_MAX = 15'h7FFF;

    // Returns {min, med, max} of three unsigned bytes.
    function automatic logic [23:0] sort3(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c < lo)      return {c, lo, hi};
        else if (c > hi) return {lo, hi, c};
        else             return {lo, c, hi};
    endfunction

    function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        logic [23:0] s;
        s = sort3(a, b, c);
        return s[15:8];
    endfunction

    // ---------------- Stage 1: per-row sort ----------------
    logic        s1_valid;
    logic [2:0][7:0] s1_min, s1_med, s1_max;
    logic [7:0]  s1_c;
    logic [23:0] row0, row1, row2;

    always_comb begin
        row0 = sort3(q00, q01, q02);
        row1 = sort3(q10, q11, q12);
        row2 = sort3(q20, q21, q22);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_min   <= '0;
            s1_med   <= '0;
            s1_max   <= '0;
            s1_c     <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_min <= {row2[23:16], row1[23:16], row0[23:16]};
                s1_med <= {row2[15:8],  row1[15:8],  row0[15:8]};
                s1_max <= {row2[7:0],   row1[7:0],   row0[7:0]};
                s1_c   <= q11;
            end
        end
    end

    // ---------------- Stage 2: column reduction ----------------
    // The median of 9 is the median of (max of row mins, median of row
    // medians, min of row maxes); the other candidates are provably excluded.
    logic        s2_valid;
    logic [7:0]  s2_lo, s2_mid, s2_hi, s2_c;
    logic [23:0] mins_s, meds_s, maxs_s;

    always_comb begin
        mins_s = sort3(s1_min[0], s1_min[1], s1_min[2]);
        meds_s = sort3(s1_med[0], s1_med[1], s1_med[2]);
        maxs_s = sort3(s1_max[0], s1_max[1], s1_max[2]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_lo    <= '0;
            s2_mid   <= '0;
            s2_hi    <= '0;
            s2_c     <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_lo  <= mins_s[7:0];
                s2_mid <= meds_s[15:8];
                s2_hi  <= maxs_s[23:16];
                s2_c   <= s1_c;
            end
        end
    end

    // ---------------- Stage 3: select, position, noise count ----------------
    logic [XW-1:0] ox;
    logic [YW-1:0] oy;
    logic [14:0]   nc;
    logic [7:0]    m;
    logic          repl;
    logic [7:0]    pix_sel;
    logic          last_x, last_y;
    logic [14:0]   nc_next;

    always_comb begin
        m       = med3(s2_lo, s2_mid, s2_hi);
        repl    = (ADAPTIVE != 0) && ((s2_c == 8'd0) || (s2_c == 8'd255));
        pix_sel = ((ADAPTIVE == 0) || repl) ? m : s2_c;
        last_x  = (ox == X_LAST);
        last_y  = (oy == Y_LAST);
        nc_next = (repl && (nc != NC_MAX)) ? nc + 15'd1 : nc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_pixel   <= '0;
            out_sof     <= 1'b0;
            out_eol     <= 1'b0;
            ox          <= '0;
            oy          <= '0;
            nc          <= '0;
            noise_count <= '0;
        end else begin
            // ox/oy hold the position of the pixel now leaving stage 2.
            out_valid <= s2_valid;
            out_sof   <= s2_valid && (ox == '0) && (oy == '0);
            out_eol   <= s2_valid && last_x;
            if (s2_valid) begin
                out_pixel <= pix_sel;
                if (last_x) begin
                    ox <= '0;
                    oy <= last_y ? '0 : oy + 1'b1;
                end else begin
                    ox <= ox + 1'b1;
                end
                if (last_x && last_y) begin
                    noise_count <= nc_next;
                    nc          <= '0;
                end else begin
                    nc <= nc_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_median3x3_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_median3x3_filter
// Description : Self-checking bench for median3x3_filter. Drives an adaptive
//               and a plain-median instance with the same windows and checks
//               pixels, latency, frame markers and noise counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_median3x3_filter;

    localparam int W = 160;
    localparam int H = 120;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [71:0] win;          // element i (i = 3*row + col) at [8*i +: 8]

    logic        ova, sofa, eola, ovb, sofb, eolb;
    logic [7:0]  pxa, pxb;
    logic [14:0] nca, ncb;

    always #5 clk = ~clk;

    median3x3_filter #(.W(W), .H(H), .ADAPTIVE(1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .q00(win[7:0]),   .q01(win[15:8]),  .q02(win[23:16]),
        .q10(win[31:24]), .q11(win[39:32]), .q12(win[47:40]),
        .q20(win[55:48]), .q21(win[63:56]), .q22(win[71:64]),
        .out_valid(ova), .out_pixel(pxa), .out_sof(sofa), .out_eol(eola),
        .noise_count(nca)
    );

    median3x3_filter #(.W(W), .H(H), .ADAPTIVE(0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .q00(win[7:0]),   .q01(win[15:8]),  .q02(win[23:16]),
        .q10(win[31:24]), .q11(win[39:32]), .q12(win[47:40]),
        .q20(win[55:48]), .q21(win[63:56]), .q22(win[71:64]),
        .out_valid(ovb), .out_pixel(pxb), .out_sof(sofb), .out_eol(eolb),
        .noise_count(ncb)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [71:0] p9(input logic [7:0] a0, input logic [7:0] a1,
            input logic [7:0] a2, input logic [7:0] a3, input logic [7:0] a4,
            input logic [7:0] a5, input logic [7:0] a6, input logic [7:0] a7,
            input logic [7:0] a8);
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [7:0] med9(input logic [71:0] w);
        logic [7:0] v [9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) v[i] = w[8*i +: 8];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        return v[4];
    endfunction

    function automatic logic [7:0] exp_adapt(input logic [71:0] w);
        logic [7:0] c;
        c = w[39:32];
        return ((c == 8'd0) || (c == 8'd255)) ? med9(w) : c;
    endfunction

    function automatic logic [71:0] rand_win();
        logic [71:0] w;
        for (int i = 0; i < 9; i++)
            w[8*i +: 8] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255))
                                                      : 8'($urandom_range(0, 3) * 85);
        return w;
    endfunction

    // ---------------- scoreboard ----------------
    int         q_cyc [$];
    logic [7:0] q_a [$];
    logic [7:0] q_b [$];
    int         mx = 0, my = 0;
    int         n_out = 0, n_eol = 0, n_sof = 0;
    int         ec;
    logic [7:0] ea, eb;

    always @(negedge clk) begin
        if (ova === 1'b1) begin
            if (q_cyc.size() == 0) begin
                check("spurious_valid", 32'(ova), 32'd0);
            end else begin
                ec = q_cyc.pop_front();
                ea = q_a.pop_front();
                eb = q_b.pop_front();
                check("latency",      32'(cyc), 32'(ec));
                check("pix_adaptive", 32'(pxa), 32'(ea));
                check("pix_median",   32'(pxb), 32'(eb));
                check("valid_b",      32'(ovb), 32'd1);
                check("sof",          32'(sofa), 32'(mx == 0 && my == 0));
                check("eol",          32'(eola), 32'(mx == W - 1));
                n_out++;
                if (eola) n_eol++;
                if (sofa) n_sof++;
                if (mx == W - 1) begin
                    mx = 0;
                    my = (my == H - 1) ? 0 : my + 1;
                end else begin
                    mx++;
                end
            end
        end else if (q_cyc.size() != 0 && q_cyc[0] <= cyc) begin
            check("missing_valid", 32'(ova), 32'd1);
            void'(q_cyc.pop_front());
            void'(q_a.pop_front());
            void'(q_b.pop_front());
        end
    end

    // Called #1 after posedge k; the window is sampled at k+1 and must
    // appear after posedge k+3.
    task automatic push_exp(input logic [7:0] xa, input logic [7:0] xb);
        q_cyc.push_back(cyc + 3);
        q_a.push_back(xa);
        q_b.push_back(xb);
    endtask

    task automatic drive_exp(input logic v, input logic [71:0] w,
                             input logic [7:0] xa, input logic [7:0] xb);
        @(posedge clk);
        #1;
        in_valid = v;
        win      = w;
        if (v) push_exp(xa, xb);
    endtask

    task automatic drive(input logic v, input logic [71:0] w);
        drive_exp(v, w, exp_adapt(w), med9(w));
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, win);
    endtask

    task automatic flush_model();
        q_cyc.delete();
        q_a.delete();
        q_b.delete();
        mx = 0;
        my = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        flush_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int imp_idx [7] = '{0, 159, 160, 5000, 12345, 19198, 19199};

    function automatic bit is_imp(input int i);
        foreach (imp_idx[k]) if (imp_idx[k] == i) return 1'b1;
        return 1'b0;
    endfunction

    logic [71:0] w;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        win      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid",   32'(ova), 32'd0);
        check("rst_out_pixel",   32'(pxa), 32'd0);
        check("rst_out_sof",     32'(sofa), 32'd0);
        check("rst_out_eol",     32'(eola), 32'd0);
        check("rst_noise_count", 32'(nca), 32'd0);
        check("rst_b_valid",     32'(ovb), 32'd0);
        reset = 1'b0;

        // Directed windows with hand-computed results (adaptive, median).
        drive_exp(1'b1, p9(100, 100, 100, 100, 100, 100, 100, 100, 100), 8'd100, 8'd100);
        idle(4);
        check("nc_uniform", 32'(nca), 32'd0);
        drive_exp(1'b1, p9(10, 20, 30, 40, 255, 60, 70, 80, 90), 8'd60, 8'd60);
        drive_exp(1'b1, p9(10, 20, 30, 40, 50, 60, 70, 80, 90), 8'd50, 8'd50);
        drive_exp(1'b0, p9(1, 1, 1, 1, 1, 1, 1, 1, 1), 8'd0, 8'd0);
        drive_exp(1'b1, p9(0, 0, 0, 0, 0, 255, 255, 255, 255), 8'd0, 8'd0);
        drive_exp(1'b1, p9(0, 0, 0, 0, 255, 255, 255, 255, 255), 8'd255, 8'd255);
        drive_exp(1'b1, p9(200, 10, 30, 250, 77, 5, 90, 120, 60), 8'd77, 8'd77);
        drive_exp(1'b1, p9(9, 8, 7, 6, 200, 4, 3, 2, 1), 8'd200, 8'd6);
        idle(6);
        check("nc_no_frame_end", 32'(nca), 32'd0);

        // Reset with two pixels in flight and in_valid held high across it.
        drive_exp(1'b1, p9(1, 2, 3, 4, 5, 6, 7, 8, 9), 8'd5, 8'd5);
        drive_exp(1'b1, p9(9, 9, 9, 9, 9, 9, 9, 9, 9), 8'd9, 8'd9);
        @(posedge clk);
        #1;
        reset = 1'b1;
        flush_model();
        @(posedge clk);
        #1;
        check("valid_in_reset", 32'(ova), 32'd0);
        reset = 1'b0;
        win   = p9(33, 33, 33, 33, 33, 33, 33, 33, 33);
        push_exp(8'd33, 8'd33);
        repeat (5) drive(1'b1, rand_win());
        idle(6);
        check("nc_after_reset", 32'(nca), 32'd0);

        // Full frame, in_valid toggling, 7 impulse centres.
        idle(2);
        do_reset();
        n_out = 0;
        n_eol = 0;
        n_sof = 0;
        for (int i = 0; i < W * H; i++) begin
            w = rand_win();
            if (is_imp(i)) w[39:32] = (i % 2 != 0) ? 8'd255 : 8'd0;
            else           w[39:32] = 8'($urandom_range(1, 254));
            drive(1'b1, w);
            drive(1'b0, w);
            if (i == 10000) check("nc_midframe", 32'(nca), 32'd0);
        end
        idle(6);
        check("frame_outputs",   32'(n_out), 32'(W * H));
        check("frame_eol_count", 32'(n_eol), 32'(H));
        check("frame_sof_count", 32'(n_sof), 32'd1);
        check("frame_noise",     32'(nca), 32'd7);
        check("frame_noise_b",   32'(ncb), 32'd0);
        drive(1'b1, rand_win());
        idle(6);
        check("second_frame_sof", 32'(n_sof), 32'd2);

        // Random windows with random gaps.
        for (int i = 0; i < 3000; i++) begin
            w = rand_win();
            drive(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, w);
        end
        idle(6);
        check("queue_drained", 32'(q_cyc.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
